// File: rtl/alu_axi_sequencer.sv
`default_nettype none
// alu_axi_sequencer - round-robin AXI4-Lite master sharing one memory-mapped ALU slave.
// Rev 1.0: each grant runs write A, write B, write OpCode, read Result, then returns the result.
module alu_axi_sequencer #(
  parameter int          NUM_REQ   = 4,
  parameter int          ID_W      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  AW_VALID,
  input  logic                  AW_READY,
  output logic [31:0]           AW_ADDR,
  output logic                  W_VALID,
  input  logic                  W_READY,
  output logic [31:0]           W_DATA,
  input  logic                  B_VALID,
  output logic                  B_READY,
  input  logic [1:0]            B_RESP,
  output logic                  AR_VALID,
  input  logic                  AR_READY,
  output logic [31:0]           AR_ADDR,
  input  logic                  R_VALID,
  output logic                  R_READY,
  input  logic [31:0]           R_DATA,
  input  logic [1:0]            R_RESP
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_A   = 3'd1,
    WR_B   = 3'd2,
    WR_OP  = 3'd3,
    RD_RES = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [ID_W-1:0] r_last, r_gnt, w_gnt, w_idx;
  logic            w_any;
  logic [31:0]     r_b, r_rsp_data, r_aw_addr, r_w_data, r_ar_addr;
  logic            r_op, r_err;
  logic            r_aw_valid, r_w_valid, r_aw_done, r_w_done, r_ar_valid, r_ar_done;
  logic            w_wr_state, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  // Search starts one past the previous grant so every requester gets a turn.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_wr_state = (r_state == WR_A) || (r_state == WR_B) || (r_state == WR_OP);
  assign B_READY    = w_wr_state && r_aw_done && r_w_done;
  assign R_READY    = (r_state == RD_RES) && r_ar_done;
  assign w_aw_hs    = r_aw_valid && AW_READY;
  assign w_w_hs     = r_w_valid && W_READY;
  assign w_b_hs     = B_READY && B_VALID;
  assign w_ar_hs    = r_ar_valid && AR_READY;
  assign w_r_hs     = R_READY && R_VALID;

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_gnt;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_err;
  assign AW_VALID  = r_aw_valid;
  assign AW_ADDR   = r_aw_addr;
  assign W_VALID   = r_w_valid;
  assign W_DATA    = r_w_data;
  assign AR_VALID  = r_ar_valid;
  assign AR_ADDR   = r_ar_addr;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      IDLE: if (w_any) begin
        req_ready[w_gnt] = 1'b1;
        w_state_nxt      = WR_A;
      end
      WR_A:   if (w_b_hs) w_state_nxt = (B_RESP != 2'b00) ? RESP : WR_B;
      WR_B:   if (w_b_hs) w_state_nxt = (B_RESP != 2'b00) ? RESP : WR_OP;
      WR_OP:  if (w_b_hs) w_state_nxt = (B_RESP != 2'b00) ? RESP : RD_RES;
      RD_RES: if (w_r_hs) w_state_nxt = RESP;
      RESP:   if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_last     <= ID_W'(NUM_REQ - 1);
      r_gnt      <= '0;
      r_b        <= '0;
      r_op       <= 1'b0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_ar_valid <= 1'b0;
      r_ar_done  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_ar_addr  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_valid <= 1'b0;
        r_aw_done  <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_valid <= 1'b0;
        r_w_done  <= 1'b1;
      end
      if (w_ar_hs) begin
        r_ar_valid <= 1'b0;
        r_ar_done  <= 1'b1;
      end
      if (r_state == IDLE && w_any) begin
        r_b    <= req_b[w_gnt*32 +: 32];
        r_op   <= req_op[w_gnt];
        r_gnt  <= w_gnt;
        r_last <= w_gnt;
      end
      if (w_b_hs && B_RESP != 2'b00) begin
        r_err      <= 1'b1;
        r_rsp_data <= '0;
      end
      if (w_r_hs) begin
        r_rsp_data <= R_DATA;
        if (R_RESP != 2'b00) r_err <= 1'b1;
      end
      if (rsp_valid && rsp_ready) r_err <= 1'b0;
      // Each bus step is launched on the edge that enters its state.
      if (w_state_nxt != r_state) begin
        if (w_state_nxt == WR_A || w_state_nxt == WR_B || w_state_nxt == WR_OP) begin
          r_aw_valid <= 1'b1;
          r_w_valid  <= 1'b1;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
        end
        case (w_state_nxt)
          WR_A: begin
            r_aw_addr <= BASE_ADDR;
            r_w_data  <= req_a[w_gnt*32 +: 32];
          end
          WR_B: begin
            r_aw_addr <= BASE_ADDR + 32'h4;
            r_w_data  <= r_b;
          end
          WR_OP: begin
            r_aw_addr <= BASE_ADDR + 32'h8;
            r_w_data  <= {31'b0, r_op};
          end
          RD_RES: begin
            r_ar_valid <= 1'b1;
            r_ar_done  <= 1'b0;
            r_ar_addr  <= BASE_ADDR + 32'hC;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
